// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit seven-segment bus, filters
// each {seg,an} pattern for stability, decodes lit digits back to BCD and
// assembles a 4-digit frame presented over a valid/ready handshake.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   seg_in[6:0]       - segment bus, bit0=A .. bit6=G
//   an_in[3:0]        - anode bus, bit0 = rightmost digit
//   frame_ready       - consumer accepts the presented frame
//   err_clr           - synchronous clear of sticky error flags
//   digits[15:0]      - digit d value at [4d+3:4d]
//   blank[3:0]        - digit d was dark
//   frame_valid       - digits/blank hold a complete frame
//   err_invalid       - sticky: lit pattern not 0-9 and not blank
//   err_multi         - sticky: more than one anode active at commit
//   err_overrun       - sticky: frame completed while previous still pending
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  input  logic        frame_ready,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        err_invalid,
  output logic        err_multi,
  output logic        err_overrun
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  // Input stage, normalised to active-high
  logic [SEG_W-1:0] w_seg_norm, r_seg, r_seg_prev;
  logic [AN_W-1:0]  w_an_norm, r_an, r_an_prev;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             w_same, w_commit;

  assign w_seg_norm = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
  assign w_an_norm  = AN_ACTIVE_LOW  ? ~an_in  : an_in;

  assign w_same   = ({r_seg, r_an} == {r_seg_prev, r_an_prev});
  // Commit only on the transition into the saturated count
  assign w_commit = w_same && (r_cnt == (STABLE_MAX - CNT_W'(1)));

  always_comb begin
    w_cnt_n = r_cnt;
    if (!w_same)                 w_cnt_n = CNT_W'(1);
    else if (r_cnt != STABLE_MAX) w_cnt_n = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= '0;
      r_an       <= '0;
      r_seg_prev <= '0;
      r_an_prev  <= '0;
      r_cnt      <= '0;
    end else begin
      r_seg      <= w_seg_norm;
      r_an       <= w_an_norm;
      r_seg_prev <= r_seg;
      r_an_prev  <= r_an;
      r_cnt      <= w_cnt_n;
    end
  end

  // Pattern decode
  logic             w_dec_ok, w_dec_blank;
  logic [DIG_W-1:0] w_dec_val;

  always_comb begin
    w_dec_ok    = 1'b1;
    w_dec_blank = 1'b0;
    w_dec_val   = '0;
    case (r_seg)
      7'h3F: w_dec_val = DIG_W'(0);
      7'h06: w_dec_val = DIG_W'(1);
      7'h5B: w_dec_val = DIG_W'(2);
      7'h4F: w_dec_val = DIG_W'(3);
      7'h66: w_dec_val = DIG_W'(4);
      7'h6D: w_dec_val = DIG_W'(5);
      7'h7D: w_dec_val = DIG_W'(6);
      7'h07: w_dec_val = DIG_W'(7);
      7'h7F: w_dec_val = DIG_W'(8);
      7'h6F: w_dec_val = DIG_W'(9);
      7'h00: w_dec_blank = 1'b1;
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Anode classification
  logic       w_one_hot, w_multi;
  logic [1:0] w_idx;

  always_comb begin
    w_one_hot = 1'b1;
    w_idx     = 2'd0;
    case (r_an)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_one_hot = 1'b0;
    endcase
  end

  assign w_multi = (r_an != '0) && !w_one_hot;

  // Frame assembly and handshake
  logic [AN_W-1:0][DIG_W-1:0] r_work, w_work_n;
  logic [AN_W-1:0]            r_wblank, w_wblank_n, r_seen, w_seen_n;
  logic [15:0]                r_digits, w_digits_n;
  logic [AN_W-1:0]            r_blank, w_blank_n;
  logic                       r_fv, w_fv_n;
  logic                       r_err_inv, r_err_mul, r_err_ovr;
  logic                       w_set_inv, w_set_mul, w_set_ovr;

  always_comb begin
    w_work_n   = r_work;
    w_wblank_n = r_wblank;
    w_seen_n   = r_seen;
    w_digits_n = r_digits;
    w_blank_n  = r_blank;
    w_fv_n     = r_fv;
    w_set_inv  = 1'b0;
    w_set_mul  = 1'b0;
    w_set_ovr  = 1'b0;

    if (w_commit) begin
      if (w_multi) begin
        w_set_mul = 1'b1;
      end else if (w_one_hot) begin
        if (w_dec_ok) begin
          w_work_n[w_idx]   = w_dec_val;
          w_wblank_n[w_idx] = w_dec_blank;
          w_seen_n[w_idx]   = 1'b1;
        end else begin
          w_set_inv = 1'b1;
        end
      end
    end

    // A completing frame may replace one being accepted on this same edge
    if (r_fv && frame_ready) w_fv_n = 1'b0;
    if (w_seen_n == 4'hF) begin
      if (!r_fv || frame_ready) begin
        w_digits_n = w_work_n;
        w_blank_n  = w_wblank_n;
        w_fv_n     = 1'b1;
      end else begin
        w_set_ovr = 1'b1;
      end
      w_seen_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_wblank  <= '0;
      r_seen    <= '0;
      r_digits  <= '0;
      r_blank   <= 4'hF;
      r_fv      <= 1'b0;
      r_err_inv <= 1'b0;
      r_err_mul <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      r_work    <= w_work_n;
      r_wblank  <= w_wblank_n;
      r_seen    <= w_seen_n;
      r_digits  <= w_digits_n;
      r_blank   <= w_blank_n;
      r_fv      <= w_fv_n;
      r_err_inv <= w_set_inv | (r_err_inv & ~err_clr);
      r_err_mul <= w_set_mul | (r_err_mul & ~err_clr);
      r_err_ovr <= w_set_ovr | (r_err_ovr & ~err_clr);
    end
  end

  assign digits      = r_digits;
  assign blank       = r_blank;
  assign frame_valid = r_fv;
  assign err_invalid = r_err_inv;
  assign err_multi   = r_err_mul;
  assign err_overrun = r_err_ovr;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans from the test plan followed by
// random scans, every cycle compared against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic        frame_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid, err_invalid, err_multi, err_overrun;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .frame_ready(frame_ready), .err_clr(err_clr), .digits(digits), .blank(blank),
    .frame_valid(frame_valid), .err_invalid(err_invalid), .err_multi(err_multi),
    .err_overrun(err_overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Active-high {G..A} pattern for each decimal value
  logic [6:0] pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state
  logic [10:0] m_pend, m_last;
  int          m_run;
  logic [3:0]  m_seen, m_wblank, m_blank;
  logic [15:0] m_work, m_digits;
  logic        m_fv, m_einv, m_emul, m_eovr;

  task automatic model_reset();
    m_pend = '0; m_last = '0; m_run = 0;
    m_seen = '0; m_wblank = '0; m_work = '0;
    m_digits = '0; m_blank = 4'hF; m_fv = 1'b0;
    m_einv = 1'b0; m_emul = 1'b0; m_eovr = 1'b0;
  endtask

  // One clock edge: the sample taken on the previous edge extends or restarts
  // its run; reaching S consecutive identical samples commits that pattern.
  task automatic model_edge();
    logic [10:0] v;
    logic [6:0]  sg;
    logic [3:0]  an;
    logic        commit, si, sm, so;
    int          d, val;
    commit = 1'b0; si = 1'b0; sm = 1'b0; so = 1'b0;
    v = m_pend;
    if (v == m_last) begin
      if (m_run < S) begin
        m_run++;
        commit = (m_run == S);
      end
    end else begin
      m_run = 1;
    end
    m_last = v;
    m_pend = {~seg_in, ~an_in};
    if (commit) begin
      sg = v[10:4];
      an = v[3:0];
      if ($countones(an) > 1) begin
        sm = 1'b1;
      end else if ($countones(an) == 1) begin
        d = 0;
        for (int i = 0; i < 4; i++) if (an[i]) d = i;
        val = -1;
        for (int k = 0; k < 10; k++) if (pat_tbl[k] == sg) val = k;
        if (sg == 7'h00) begin
          m_work[4*d +: 4] = 4'h0; m_wblank[d] = 1'b1; m_seen[d] = 1'b1;
        end else if (val >= 0) begin
          m_work[4*d +: 4] = 4'(val); m_wblank[d] = 1'b0; m_seen[d] = 1'b1;
        end else begin
          si = 1'b1;
        end
      end
    end
    if (m_seen == 4'hF) begin
      if (!m_fv || frame_ready) begin
        m_digits = m_work; m_blank = m_wblank; m_fv = 1'b1;
      end else begin
        so = 1'b1;
      end
      m_seen = '0;
    end else if (m_fv && frame_ready) begin
      m_fv = 1'b0;
    end
    m_einv = si | (m_einv & ~err_clr);
    m_emul = sm | (m_emul & ~err_clr);
    m_eovr = so | (m_eovr & ~err_clr);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("digits",      digits,              m_digits);
    chk("blank",       16'(blank),          16'(m_blank));
    chk("frame_valid", 16'(frame_valid),    16'(m_fv));
    chk("err_invalid", 16'(err_invalid),    16'(m_einv));
    chk("err_multi",   16'(err_multi),      16'(m_emul));
    chk("err_overrun", 16'(err_overrun),    16'(m_eovr));
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] a, input logic rdy, input logic clr);
    seg_in = s; an_in = a; frame_ready = rdy; err_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(s, a, 1'b0, 1'b0);
  endtask

  // Four digits held 6 cycles each; frame_ready raised on step rdy_at of d3
  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input int rdy_at);
    hold(s0, 4'b1110, 6);
    hold(s1, 4'b1101, 6);
    hold(s2, 4'b1011, 6);
    for (int i = 1; i <= 6; i++) step(s3, 4'b0111, (i == rdy_at), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    chk("rst_digits", digits, 16'h0000);
    chk("rst_blank",  16'(blank), 16'h000F);
    chk("rst_fv",     16'(frame_valid), 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] rs;
    logic [3:0] ra;
    int         r, hl;
    model_reset();
    #2;
    do_reset();

    // Basic scan 7,0,1,2 with latency check on d3
    hold(7'h78, 4'b1110, 6);
    hold(7'h40, 4'b1101, 6);
    hold(7'h79, 4'b1011, 6);
    hold(7'h24, 4'b0111, S);
    chk("tp1_fv_early", 16'(frame_valid), 16'h0000);
    hold(7'h24, 4'b0111, 1);
    chk("tp1_fv_rise", 16'(frame_valid), 16'h0001);
    hold(7'h24, 4'b0111, 1);
    chk("tp1_digits", digits, 16'h2107);
    chk("tp1_blank",  16'(blank), 16'h0000);
    step(7'h7F, 4'hF, 1'b1, 1'b0);
    chk("tp1_accept", 16'(frame_valid), 16'h0000);

    // d1 blank, then an invalid d1 blocks the frame until rescanned
    scan(7'h78, 7'h7F, 7'h79, 7'h24, 0);
    chk("tp2_blank",  16'(blank), 16'h0002);
    chk("tp2_digits", digits, 16'h2107);
    step(7'h7F, 4'hF, 1'b1, 1'b0);
    scan(7'h78, 7'h6B, 7'h79, 7'h24, 0);
    chk("tp2_nofv", 16'(frame_valid), 16'h0000);
    chk("tp2_inv",  16'(err_invalid), 16'h0001);
    hold(7'h40, 4'b1101, 6);
    chk("tp2_fv", 16'(frame_valid), 16'h0001);
    step(7'h7F, 4'hF, 1'b1, 1'b1);

    // Glitch restarts the stability window
    hold(7'h78, 4'b1110, 3);
    hold(7'h79, 4'b1110, 1);
    hold(7'h78, 4'b1110, 3);
    hold(7'h78, 4'b1110, 4);
    hold(7'h12, 4'b1101, 6);
    hold(7'h02, 4'b1011, 6);
    hold(7'h10, 4'b0111, 6);
    chk("tp3_digits", digits, 16'h9657);
    step(7'h7F, 4'hF, 1'b1, 1'b0);

    // Anode collision
    hold(7'h79, 4'b0110, 6);
    chk("tp4_multi", 16'(err_multi), 16'h0001);
    step(7'h7F, 4'hF, 1'b0, 1'b1);
    chk("tp4_clr", 16'(err_multi), 16'h0000);

    // Overrun, then accept-and-reload on the completion edge
    scan(7'h78, 7'h40, 7'h79, 7'h24, 0);
    scan(7'h78, 7'h12, 7'h02, 7'h10, 0);
    chk("tp5_held", digits, 16'h2107);
    chk("tp5_ovr",  16'(err_overrun), 16'h0001);
    step(7'h7F, 4'hF, 1'b0, 1'b1);
    scan(7'h78, 7'h12, 7'h02, 7'h10, S + 1);
    chk("tp5_new",   digits, 16'h9657);
    chk("tp5_fv",    16'(frame_valid), 16'h0001);
    chk("tp5_noovr", 16'(err_overrun), 16'h0000);
    step(7'h7F, 4'hF, 1'b1, 1'b0);

    // Reset mid-scan discards the partial frame
    hold(7'h78, 4'b1110, 6);
    hold(7'h40, 4'b1101, 6);
    hold(7'h79, 4'b1011, 6);
    do_reset();
    hold(7'h24, 4'b0111, 8);
    chk("tp6_nofv", 16'(frame_valid), 16'h0000);

    // Random scanning
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 10)      rs = ~pat_tbl[r];
      else if (r < 12) rs = 7'h7F;
      else             rs = 7'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 7)       ra = ~(4'(1) << $urandom_range(0, 3));
      else if (r < 8)  ra = 4'hF;
      else             ra = 4'($urandom);
      hl = int'($urandom_range(1, 7));
      for (int i = 0; i < hl; i++)
        step(rs, ra, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
